free_list_ctrl: RTL and testbench
=================================

# free_list_ctrl

Physical-register free-list controller for the rename stage. It hands up to N_WAY free physical register tags per cycle to the map table's `pr_freelist` input, and stalls dispatch when too few tags are free. It reclaims each retired instruction's old tag (`pr_old`/Told from the ROB) and restores the speculative free list on `branch_haz`. It is a circular FIFO with a speculative head, an architectural head and a tail.

## Interface
- `N_WAY`, default 2: dispatch/retire width.
- `PR_COUNT`, default 64: number of physical registers; must be a power of 2. Tag 0 means "no register".
- `PR_BITS`, default 6: log2(PR_COUNT).
- `ARCH_REGS`, default 32: architectural registers, mapped to tags 1..ARCH_REGS at reset.

Ports:
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-low. Clears state on a rising edge with `reset`=0.
- `dis_req` input, N_WAY bits: slot n needs a tag (valid instruction with dest != 0).
- `dis_stall` input, 1 bit: dispatch is held for another reason; no tags are consumed.
- `pr_freelist` output, N_WAY×PR_BITS: tag offered to each slot; 0 for non-requesting slots or when `alloc_ok`=0.
- `alloc_ok` output, 1 bit: all requests this cycle can be satisfied.
- `ret_valid` input, N_WAY bits: slot n retires this cycle.
- `ret_alloc` input, N_WAY bits: the retiring instruction had consumed a tag at dispatch.
- `ret_told` input, N_WAY×PR_BITS: old tag released by the retiring instruction.
- `branch_haz` input, 1 bit: mispredict recovery, same meaning as at the map table.
- `free_count` output, PR_BITS+1 bits: registered number of free tags.
- `dbl_free_err` output, 1 bit: sticky error flag. Only present with the macro below; otherwise tied to 0.

## Operation
- Storage: PR_COUNT-entry tag array. Pointers `head`, `arch_head` and `tail` are PR_BITS wide and wrap modulo PR_COUNT. A `count` register holds the number of free tags.
- Reset state:
  - Entries 0..PR_COUNT-ARCH_REGS-2 hold tags ARCH_REGS+1..PR_COUNT-1 (defaults: 33..63).
  - `head` = `arch_head` = 0.
  - `tail` = PR_COUNT-ARCH_REGS-1 (31).
  - `count` = `free_count` = 31.
  - `alloc_ok` = 0 while in reset; `pr_freelist` = 0; `dbl_free_err` = 0.
- Allocation:
  - Let R = popcount(`dis_req`). `alloc_ok` = (`count` >= R) && !`branch_haz`.
  - Allocation is all-or-nothing.
  - Requesting slots are compacted in slot order: slot n receives entry[`head` + number of requesting slots below n].
  - Fire = `alloc_ok` && !`dis_stall`. On fire, `head` += R.
- Reclaim:
  - A retire slot pushes only if `ret_valid` && `ret_told` > 1. Tags 0 and 1 (the x0 mapping) are never freed.
  - Pushes are compacted in slot order at `tail`; `tail` += P, where P is the number of pushes.
- Architectural head: `arch_head` += popcount(`ret_valid` & `ret_alloc`).
- Recovery: on `branch_haz`:
  - `head` <= `arch_head` + this cycle's retire-alloc increment.
  - `count` <= `tail` - that new head + P, computed modulo PR_COUNT, except that a full list (31 + in-flight) uses the count arithmetic.
  - No pop occurs in a recovery cycle.
- Count update:
  - Normal cycle: `count` <= `count` - (fire ? R : 0) + P.
  - Recovery cycle: `count` <= (`count` + popped-not-retired tags restored) + P. This equals PR_COUNT-1-ARCH_REGS minus the tags still held by in-flight allocations older than retirement, which is zero after a flush. Implemented as `count` <= (`tail` + P - new_head) mod PR_COUNT, with result PR_COUNT treated as impossible.
- Invariant: `count` <= PR_COUNT-1-ARCH_REGS. Overflow is impossible by construction and is not checked.

## Timing
- `pr_freelist`/`alloc_ok` are combinational from the registered `head`/`count` and the current `dis_req`/`branch_haz`. The map table uses them the same cycle.
- No bypass: a tag pushed in cycle t is allocatable from cycle t+1 at the earliest.
- Simultaneous pop and push in one cycle are both applied.
- `count`=0 with R>0: `alloc_ok`=0, `pr_freelist`=0, pointers unchanged.
- R=0: `alloc_ok`=1 (unless `branch_haz`); nothing popped.
- Wrap-around: pointer arithmetic is modulo PR_COUNT. Compacted reads and writes may straddle entry PR_COUNT-1 → 0.
- Reset asserted mid-operation: all state returns to the reset state at that edge; in-flight requests are dropped.

## Configuration
- `FREE_LIST_DBL_FREE_CHECK_EN` defined:
  - Keeps a PR_COUNT-bit `is_free` vector (set on push or reset-free, cleared on pop, rebuilt from FIFO occupancy on recovery).
  - A push of a tag already free, or a duplicate tag within one cycle, is dropped.
  - Such a push sets `dbl_free_err` sticky until reset.
- Macro undefined: no vector; all qualifying pushes are accepted; `dbl_free_err` = 0.

## Test plan
- Reset then `dis_req`=2'b11 → `pr_freelist`={34,33}, `alloc_ok`=1; next cycle `free_count`=29.
- `dis_req`=2'b10 → slot 1 gets 33, slot 0 gets 0; `dis_stall`=1 for one cycle → same tag 33 re-offered next cycle.
- Drain to `count`=1, then `dis_req`=2'b11 → `alloc_ok`=0, nothing popped; same cycle retire `ret_told`={5,1} → only 5 pushed, `free_count`=2 next cycle.
- Allocate 40 tags with retires interleaved so pointers cross 63→0 → tags come out in FIFO order with no loss; `free_count` is consistent.
- Allocate 4 tags (none retired), assert `branch_haz` with one simultaneous retire of told 7 (`ret_alloc`=1) → `head` = `arch_head`+1, `free_count` = 31-1+... = restored value plus 1 push, `alloc_ok`=0 that cycle.
- With `FREE_LIST_DBL_FREE_CHECK_EN`: retire told 40 while 40 is free → push dropped, `dbl_free_err`=1 until reset.

Source files
------------

// File: rtl/free_list_ctrl.sv
// free_list_ctrl: physical-register free list for the rename stage.
// Circular FIFO of free tags with a speculative head (dispatch), an
// architectural head (retire) and a tail (reclaim). On branch_haz the
// speculative head snaps back to the architectural head.
// Optional macro FREE_LIST_DBL_FREE_CHECK_EN adds double-free filtering
// and the sticky dbl_free_err flag.
module free_list_ctrl #(
  parameter int N_WAY     = 2,
  parameter int PR_COUNT  = 64,
  parameter int PR_BITS   = 6,
  parameter int ARCH_REGS = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_WAY-1:0]           dis_req,
  input  logic                       dis_stall,
  output logic [N_WAY*PR_BITS-1:0]   pr_freelist,
  output logic                       alloc_ok,
  input  logic [N_WAY-1:0]           ret_valid,
  input  logic [N_WAY-1:0]           ret_alloc,
  input  logic [N_WAY*PR_BITS-1:0]   ret_told,
  input  logic                       branch_haz,
  output logic [PR_BITS:0]           free_count,
  output logic                       dbl_free_err
);

  localparam int CW        = PR_BITS + 1;
  localparam int INIT_FREE = PR_COUNT - ARCH_REGS - 1;

  logic [PR_BITS-1:0] r_entry [PR_COUNT];
  logic [PR_BITS-1:0] r_head, r_arch_head, r_tail;
  logic [PR_BITS:0]   r_count;

  logic [PR_BITS-1:0] w_told      [N_WAY];
  logic [PR_BITS-1:0] w_alloc_tag [N_WAY];
  logic [PR_BITS-1:0] w_push_idx  [N_WAY];
  logic [N_WAY-1:0]   w_push_cand, w_push;
  logic [PR_BITS:0]   w_req_cnt, w_push_cnt, w_ret_alloc_cnt;
  logic               w_alloc_ok, w_fire;
  logic [PR_BITS-1:0] w_new_head, w_rec_free;

  genvar g;
  generate
    for (g = 0; g < N_WAY; g++) begin : g_lane
      assign w_told[g]      = ret_told[g*PR_BITS +: PR_BITS];
      // tags 0/1 are the hardwired x0 mapping and never return to the list
      assign w_push_cand[g] = ret_valid[g] && (w_told[g] > PR_BITS'(1));
    end
  endgenerate

  // compact requesting slots onto consecutive entries from head
  always_comb begin
    w_req_cnt = '0;
    for (int n = 0; n < N_WAY; n++) begin
      w_alloc_tag[n] = r_entry[r_head + w_req_cnt[PR_BITS-1:0]];
      if (dis_req[n]) w_req_cnt = w_req_cnt + CW'(1);
    end
  end

  assign w_alloc_ok = reset && !branch_haz && (r_count >= w_req_cnt);
  assign w_fire     = w_alloc_ok && !dis_stall;
  assign alloc_ok   = w_alloc_ok;
  assign free_count = r_count;

  // offered tags, zeroed for idle slots or a refused allocation
  always_comb begin
    pr_freelist = '0;
    for (int n = 0; n < N_WAY; n++)
      if (w_alloc_ok && dis_req[n]) pr_freelist[n*PR_BITS +: PR_BITS] = w_alloc_tag[n];
  end

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  logic [PR_COUNT-1:0] r_is_free, w_is_free_nxt;
  logic                r_dbl_err, w_dbl_hit, w_dup;

  // drop pushes of tags already free or repeated earlier in the same cycle
  always_comb begin
    w_push    = '0;
    w_dbl_hit = 1'b0;
    w_dup     = 1'b0;
    for (int n = 0; n < N_WAY; n++) begin
      w_dup = 1'b0;
      for (int m = 0; m < n; m++)
        if (w_push[m] && (w_told[m] == w_told[n])) w_dup = 1'b1;
      w_push[n] = w_push_cand[n] && !r_is_free[w_told[n]] && !w_dup;
      if (w_push_cand[n] && !w_push[n]) w_dbl_hit = 1'b1;
    end
  end

  // free-tag vector: rebuilt from the surviving FIFO span on recovery
  always_comb begin
    if (branch_haz) begin
      w_is_free_nxt = '0;
      for (int i = 0; i < PR_COUNT; i++)
        if (PR_BITS'(PR_BITS'(i) - w_new_head) < w_rec_free)
          w_is_free_nxt[r_entry[i]] = 1'b1;
    end else begin
      w_is_free_nxt = r_is_free;
      if (w_fire)
        for (int n = 0; n < N_WAY; n++)
          if (dis_req[n]) w_is_free_nxt[w_alloc_tag[n]] = 1'b0;
    end
    for (int n = 0; n < N_WAY; n++)
      if (w_push[n]) w_is_free_nxt[w_told[n]] = 1'b1;
  end

  // free vector and sticky error flag
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < PR_COUNT; i++) r_is_free[i] <= (i > ARCH_REGS);
      r_dbl_err <= 1'b0;
    end else begin
      r_is_free <= w_is_free_nxt;
      r_dbl_err <= r_dbl_err | w_dbl_hit;
    end
  end

  assign dbl_free_err = r_dbl_err;
`else
  assign w_push       = w_push_cand;
  assign dbl_free_err = 1'b0;
`endif

  // compact accepted pushes from tail; count retire-side allocations
  always_comb begin
    w_push_cnt      = '0;
    w_ret_alloc_cnt = '0;
    for (int n = 0; n < N_WAY; n++) begin
      w_push_idx[n] = r_tail + w_push_cnt[PR_BITS-1:0];
      if (w_push[n]) w_push_cnt = w_push_cnt + CW'(1);
      if (ret_valid[n] && ret_alloc[n]) w_ret_alloc_cnt = w_ret_alloc_cnt + CW'(1);
    end
  end

  // recovery: everything popped but not retired goes back on the list
  assign w_new_head = r_arch_head + w_ret_alloc_cnt[PR_BITS-1:0];
  assign w_rec_free = r_tail - w_new_head;

  // pointers, count and tag storage
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < PR_COUNT; i++)
        r_entry[i] <= (i < INIT_FREE) ? PR_BITS'(i + ARCH_REGS + 1) : '0;
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= PR_BITS'(INIT_FREE);
      r_count     <= CW'(INIT_FREE);
    end else begin
      for (int n = 0; n < N_WAY; n++)
        if (w_push[n]) r_entry[w_push_idx[n]] <= w_told[n];
      r_tail      <= r_tail + w_push_cnt[PR_BITS-1:0];
      r_arch_head <= w_new_head;
      if (branch_haz) begin
        r_head  <= w_new_head;
        r_count <= {1'b0, w_rec_free} + w_push_cnt;
      end else begin
        if (w_fire) r_head <= r_head + w_req_cnt[PR_BITS-1:0];
        r_count <= r_count - (w_fire ? w_req_cnt : CW'(0)) + w_push_cnt;
      end
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl at default parameters.
module tb_free_list_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  dis_req;
  logic        dis_stall;
  logic [11:0] pr_freelist;
  logic        alloc_ok;
  logic [1:0]  ret_valid, ret_alloc;
  logic [11:0] ret_told;
  logic        branch_haz;
  logic [6:0]  free_count;
  logic        dbl_free_err;

  int tests = 0;
  int fails = 0;

  free_list_ctrl dut (
    .clock(clock), .reset(reset), .dis_req(dis_req), .dis_stall(dis_stall),
    .pr_freelist(pr_freelist), .alloc_ok(alloc_ok), .ret_valid(ret_valid),
    .ret_alloc(ret_alloc), .ret_told(ret_told), .branch_haz(branch_haz),
    .free_count(free_count), .dbl_free_err(dbl_free_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pf(input int s1, input int s0);
    return 32'({6'(s1), 6'(s0)});
  endfunction

  initial begin
    reset = 1'b0; dis_req = '0; dis_stall = 1'b0; ret_valid = '0;
    ret_alloc = '0; ret_told = '0; branch_haz = 1'b0;
    repeat (2) step();
    chk("rst_alloc_ok", 32'(alloc_ok), 0);
    chk("rst_pf", 32'(pr_freelist), 0);
    chk("rst_count", 32'(free_count), 31);
    chk("rst_dbl", 32'(dbl_free_err), 0);

    // two-wide allocation straight out of reset
    reset = 1'b1; dis_req = 2'b11; #1;
    chk("pf_11", 32'(pr_freelist), pf(34, 33));
    chk("ok_11", 32'(alloc_ok), 1);
    step(); dis_req = 2'b00; #1;
    chk("cnt_29", 32'(free_count), 29);

    // reset mid-operation with a request pending drops it
    reset = 1'b0; dis_req = 2'b11; #1;
    chk("ok_in_rst", 32'(alloc_ok), 0);
    step(); reset = 1'b1; dis_req = 2'b00; #1;
    chk("cnt_rerst", 32'(free_count), 31);

    // slot compaction and stall
    dis_req = 2'b10; dis_stall = 1'b1; #1;
    chk("pf_10", 32'(pr_freelist), pf(33, 0));
    step(); dis_stall = 1'b0; #1;
    chk("cnt_stall", 32'(free_count), 31);
    chk("pf_10_again", 32'(pr_freelist), pf(33, 0));
    step(); dis_req = 2'b01; #1;
    chk("cnt_30", 32'(free_count), 30);
    chk("pf_01", 32'(pr_freelist), pf(0, 34));
    step(); dis_req = 2'b11;

    // drain down to one free tag
    for (int k = 0; k < 14; k++) begin
      #1;
      chk("pf_drain", 32'(pr_freelist), pf(36 + 2*k, 35 + 2*k));
      step();
    end

    // count=1 with R=2: refused; retire {5,1} pushes only 5
    ret_valid = 2'b11; ret_alloc = 2'b11; ret_told = {6'd5, 6'd1}; #1;
    chk("cnt_1", 32'(free_count), 1);
    chk("ok_short", 32'(alloc_ok), 0);
    chk("pf_short", 32'(pr_freelist), 0);
    step(); ret_valid = '0; ret_alloc = '0; ret_told = '0; #1;
    chk("cnt_2", 32'(free_count), 2);
    chk("pf_5_63", 32'(pr_freelist), pf(5, 63));
    step(); dis_req = 2'b01; #1;
    chk("cnt_0", 32'(free_count), 0);
    chk("ok_empty", 32'(alloc_ok), 0);
    dis_req = 2'b00; #1;
    chk("ok_r0", 32'(alloc_ok), 1);

    // 40 allocations with interleaved retires; both pointers wrap
    for (int c = 0; c < 22; c++) begin
      ret_valid = 2'b11; ret_alloc = 2'b11;
      ret_told = {6'(2*c + 3), 6'(2*c + 2)};
      dis_req = (c >= 1 && c <= 20) ? 2'b11 : 2'b00;
      #1;
      if (c >= 1 && c <= 20) chk("pf_wrap", 32'(pr_freelist), pf(2*c + 1, 2*c));
      step();
    end
    ret_valid = '0; ret_alloc = '0; ret_told = '0; dis_req = 2'b11; #1;
    chk("cnt_wrap", 32'(free_count), 4);
    chk("pf_after_wrap", 32'(pr_freelist), pf(43, 42));

    // recovery: 4 allocated, flush with one retire of told 7
    reset = 1'b0; dis_req = 2'b00; step();
    reset = 1'b1; dis_req = 2'b11; step(); step(); #1;
    chk("cnt_27", 32'(free_count), 27);
    branch_haz = 1'b1; ret_valid = 2'b01; ret_alloc = 2'b01; ret_told = {6'd0, 6'd7}; #1;
    chk("ok_haz", 32'(alloc_ok), 0);
    chk("pf_haz", 32'(pr_freelist), 0);
    step(); branch_haz = 1'b0; ret_valid = '0; ret_alloc = '0; ret_told = '0; #1;
    chk("cnt_rec", 32'(free_count), 31);
    chk("pf_rec", 32'(pr_freelist), pf(35, 34));
    step(); dis_req = 2'b00; #1;
    chk("cnt_rec2", 32'(free_count), 29);

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    // double free of tag 40 (free since reset) is dropped and flagged
    reset = 1'b0; step(); reset = 1'b1;
    ret_valid = 2'b01; ret_told = {6'd0, 6'd40}; step();
    ret_valid = '0; ret_told = '0; #1;
    chk("dbl_cnt", 32'(free_count), 31);
    chk("dbl_flag", 32'(dbl_free_err), 1);
    step();
    chk("dbl_sticky", 32'(dbl_free_err), 1);
    reset = 1'b0; step(); reset = 1'b1;
    chk("dbl_clr", 32'(dbl_free_err), 0);
`else
    chk("dbl_tied", 32'(dbl_free_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
